// File: rtl/hcsr04_pkg.sv
// HC-SR04 emulator shared types, default timings and helpers.
// Imported by the emulator and by ultrasonic_distance_sensor tests.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  localparam int DEF_CLK_HZ      = 27_000_000;
  localparam int DEF_DIST_W      = 16;
  localparam int DEF_MIN_TRIG_US = 10;
  localparam int DEF_BURST_US    = 200;
  localparam int DEF_US_PER_CM   = 58;
  localparam int DEF_MAX_CM      = 400;
  localparam int DEF_TIMEOUT_US  = 38000;
  localparam int DEF_HOLDOFF_US  = 10000;

  function automatic int us_to_cycles(input int clk_hz, input int us);
    longint p;
    p = longint'(clk_hz) * longint'(us) / longint'(1000000);
    return int'(p);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hcsr04_echo_emulator_sync_2ff.sv
// Generic two-flop synchronizer for slow asynchronous inputs.
// Ports: clk, rst (async high), i_d (async in), o_q (synchronized out).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 sensor-side responder: trig in, distance-coded echo out.
// Ports: clk, rst (async high), trig (async), distance_cm,
//   object_present; echo, busy, trig_rejected (1-cycle pulse).
module hcsr04_echo_emulator
  import hcsr04_pkg::*;
#(
  parameter int clk_frequency  = DEF_CLK_HZ,
  parameter int distance_width = DEF_DIST_W,
  parameter int min_trig_us    = DEF_MIN_TRIG_US,
  parameter int burst_us       = DEF_BURST_US,
  parameter int us_per_cm      = DEF_US_PER_CM,
  parameter int max_cm         = DEF_MAX_CM,
  parameter int timeout_us     = DEF_TIMEOUT_US,
  parameter int holdoff_us     = DEF_HOLDOFF_US
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trig,
  input  logic [distance_width-1:0] distance_cm,
  input  logic                      object_present,
  output logic                      echo,
  output logic                      busy,
  output logic                      trig_rejected
);

  localparam int MIN_C = us_to_cycles(clk_frequency, min_trig_us);
  localparam int BUR_C = us_to_cycles(clk_frequency, burst_us);
  localparam int CPC_C = us_to_cycles(clk_frequency, us_per_cm);
  localparam int TO_C  = us_to_cycles(clk_frequency, timeout_us);
  localparam int HO_C  = us_to_cycles(clk_frequency, holdoff_us);

  localparam int TICK_MAX =
    imax(imax(imax(MIN_C, BUR_C), imax(TO_C, HO_C)), CPC_C);
  localparam int TW  = $clog2(TICK_MAX + 1);
  localparam int CMW = $clog2(max_cm + 1);

  localparam logic [TW-1:0] MIN_T = TW'(MIN_C);
  localparam logic [TW-1:0] BUR_T = TW'(BUR_C - 1);
  localparam logic [TW-1:0] CPC_T = TW'(CPC_C - 1);
  localparam logic [TW-1:0] TO_T  = TW'(TO_C - 1);
  localparam logic [TW-1:0] HO_T  = TW'(HO_C - 1);

  localparam logic [distance_width-1:0] MAX_CM_D =
    distance_width'(max_cm);

  logic          w_trig_s;
  logic          r_trig_d;
  logic          w_rise;
  logic          w_fall;
  logic          w_long;
  logic          w_echo_done;
  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_tick;
  logic [CMW-1:0] r_cm;
  logic          r_timeout;

  sync_2ff #(.W(1)) u_trig_sync (
    .clk (clk),
    .rst (rst),
    .i_d (trig),
    .o_q (w_trig_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_trig_d <= 1'b0;
    else     r_trig_d <= w_trig_s;
  end

  assign w_rise = w_trig_s & ~r_trig_d;
  assign w_fall = ~w_trig_s & r_trig_d;
  assign w_long = (r_tick >= MIN_T);

  // Timeout mode is one flat count; distance mode is cm x cycles/cm.
  assign w_echo_done = r_timeout ? (r_tick == TO_T)
                                 : (r_tick == CPC_T) &&
                                   (r_cm == CMW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_rise) w_next = S_TRIG;
      S_TRIG:    if (w_fall) w_next = w_long ? S_BURST : S_IDLE;
      S_BURST:   if (r_tick == BUR_T) w_next = S_ECHO;
      S_ECHO:    if (w_echo_done) w_next = S_HOLDOFF;
      S_HOLDOFF: if (r_tick == HO_T) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick    <= '0;
      r_cm      <= '0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        // The rise cycle is already the first high cycle of trig_s.
        S_IDLE: if (w_rise) r_tick <= TW'(1);
        S_TRIG: begin
          if (w_fall) begin
            r_tick <= '0;
            if (!object_present || distance_cm > MAX_CM_D) begin
              r_timeout <= 1'b1;
              r_cm      <= '0;
            end else begin
              r_timeout <= 1'b0;
              r_cm      <= (distance_cm == '0) ? CMW'(1)
                                               : CMW'(distance_cm);
            end
          end else if (r_tick != MIN_T) begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_BURST:
          r_tick <= (r_tick == BUR_T) ? '0 : r_tick + TW'(1);
        S_ECHO: begin
          if (r_timeout) begin
            r_tick <= w_echo_done ? '0 : r_tick + TW'(1);
          end else if (r_tick == CPC_T) begin
            r_tick <= '0;
            r_cm   <= r_cm - CMW'(1);
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_HOLDOFF:
          r_tick <= (r_tick == HO_T) ? '0 : r_tick + TW'(1);
        default: r_tick <= '0;
      endcase
    end
  end

  always_comb begin
    echo          = (r_state == S_ECHO);
    busy          = (r_state != S_IDLE);
    trig_rejected = (r_state == S_TRIG) && w_fall && !w_long;
  end

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Scoreboard bench for hcsr04_echo_emulator at 1 MHz (1 cycle = 1 us).
// Timeout/holdoff shortened to keep the run short.
module tb_hcsr04_echo_emulator;

  localparam int TO_CYC  = 3800;
  localparam int HO_CYC  = 1000;
  // 2 sync flops + fall-detect cycle + 200-cycle burst.
  localparam int LAT     = 203;

  typedef struct {
    int w;
    int lat;
    bit rej;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic [15:0] distance_cm;
  logic        object_present;
  logic        echo;
  logic        busy;
  logic        trig_rejected;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   n_echo = 0;
  int   n_rej = 0;
  int   ew = 0;
  int   rw = 0;
  logic echo_q = 1'b0;
  logic rej_q = 1'b0;

  hcsr04_echo_emulator #(
    .clk_frequency (1000000),
    .timeout_us    (TO_CYC),
    .holdoff_us    (HO_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trig           (trig),
    .distance_cm    (distance_cm),
    .object_present (object_present),
    .echo           (echo),
    .busy           (busy),
    .trig_rejected  (trig_rejected)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (echo) begin
      if (!echo_q) begin
        n_echo++;
        chk("echo_busy", int'(busy), 1);
        if (sb.size() == 0) chk("echo_unexpected", 1, 0);
        else chk("echo_latency", cyc - fall_cyc, sb[0].lat);
      end
      ew++;
    end else if (echo_q) begin
      if (sb.size() == 0) begin
        chk("echo_unexpected_end", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("echo_kind", 0, int'(e.rej));
        chk("echo_width", ew, e.w);
      end
      ew = 0;
    end
    echo_q = echo;

    if (trig_rejected) begin
      if (!rej_q) n_rej++;
      rw++;
    end else if (rej_q) begin
      if (sb.size() == 0) begin
        chk("rej_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rej_kind", 1, int'(e.rej));
        chk("rej_width", rw, 1);
      end
      rw = 0;
    end
    rej_q = trig_rejected;
  end

  task automatic pulse(input int hi);
    @(negedge clk);
    trig = 1'b1;
    repeat (hi) @(negedge clk);
    trig = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic push_echo(input int w);
    exp_t e;
    e.w = w; e.lat = LAT; e.rej = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_rej();
    exp_t e;
    e.w = 1; e.lat = 0; e.rej = 1'b1;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_echo(input logic lvl, input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (echo !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (echo !== lvl) chk("echo_wait_timeout", int'(echo), int'(lvl));
  endtask

  initial begin
    rst = 1'b1;
    trig = 1'b0;
    distance_cm = 16'd10;
    object_present = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rej", int'(trig_rejected), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // valid trigger, 10 cm
    push_echo(580);
    pulse(12);
    repeat (50) @(negedge clk);
    chk("busy_in_burst", int'(busy), 1);
    wait_idle(10000);

    // exactly min_trig high is accepted
    push_echo(580);
    pulse(10);
    wait_idle(10000);

    // one short of min_trig, and a clearly short one
    push_rej();
    pulse(9);
    wait_idle(100);
    push_rej();
    pulse(5);
    wait_idle(100);
    chk("busy_after_rej", int'(busy), 0);

    // no object, then out-of-range distance
    object_present = 1'b0;
    push_echo(TO_CYC);
    pulse(12);
    wait_idle(10000);
    object_present = 1'b1;
    distance_cm = 16'd401;
    push_echo(TO_CYC);
    pulse(12);
    wait_idle(10000);

    // zero clamps to 1 cm
    distance_cm = 16'd0;
    push_echo(58);
    pulse(12);
    wait_idle(10000);

    // latch during burst, trig ignored in ECHO / HOLDOFF
    distance_cm = 16'd10;
    push_echo(580);
    pulse(12);
    repeat (50) @(negedge clk);
    distance_cm = 16'd50;
    wait_echo(1'b1, 1000);
    repeat (100) @(negedge clk);
    pulse(12);
    wait_echo(1'b0, 2000);
    repeat (100) @(negedge clk);
    pulse(12);
    // trig held across return to IDLE must not start a measurement
    trig = 1'b1;
    wait_idle(10000);
    repeat (20) @(negedge clk);
    chk("held_trig_busy", int'(busy), 0);
    trig = 1'b0;
    repeat (20) @(negedge clk);
    chk("held_trig_release", int'(busy), 0);

    // fresh trig measures the new distance
    push_echo(2900);
    pulse(12);
    wait_idle(10000);

    // reset 100 cycles into echo
    distance_cm = 16'd10;
    push_echo(100);
    pulse(12);
    wait_echo(1'b1, 1000);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_echo", int'(echo), 0);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    push_echo(580);
    pulse(12);
    wait_idle(10000);

    repeat (5) @(negedge clk);
    chk("sb_left", sb.size(), 0);
    chk("echo_count", n_echo, 9);
    chk("rej_count", n_rej, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got running expected finished");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
